jk_fault_driver: RTL and testbench

//  Upstream driver for a bank of WIDTH jk_ff cells used as fault-injection targets.
//  - Accepts one fault command at a time: target bit, JK mode, delay, duration, restore flag.
//  - Drives that bit's J/K pair for a timed window, then optionally restores the bit's pre-fault value.
//  - Sits between the campaign controller (command source) and the jk_ff bank (J/K sink, Q observed back).

---
 rtl/fault_pkg.sv | 22 ++
 rtl/jk_fault_driver_if.sv | 39 +++
 rtl/fault_dncnt.sv | 36 +++
 rtl/jk_fault_driver.sv | 185 ++++++++++++++++++
 tb/tb_jk_fault_driver.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fault_pkg.sv
// Shared mode codes, FSM encodings and helpers
// for the jk_ff fault-injection driver.
package fault_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_CLR  = 2'b01;
  localparam logic [1:0] MODE_SET  = 2'b10;
  localparam logic [1:0] MODE_TGL  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DELAY   = 3'd1,
    ST_ACTIVE  = 3'd2,
    ST_RESTORE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  function automatic int idx_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/jk_fault_driver_if.sv
// Fault command handshake between the campaign
// controller (master) and the driver (slave).
interface jk_fault_driver_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  import fault_pkg::*;

  localparam int IDX_W = idx_width(WIDTH);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [IDX_W-1:0] cmd_idx;
  logic [1:0]       cmd_mode;
  logic [CNT_W-1:0] cmd_delay;
  logic [CNT_W-1:0] cmd_dur;
  logic             cmd_restore;

  modport master (
    output cmd_valid,
    output cmd_idx,
    output cmd_mode,
    output cmd_delay,
    output cmd_dur,
    output cmd_restore,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_idx,
    input  cmd_mode,
    input  cmd_delay,
    input  cmd_dur,
    input  cmd_restore,
    output cmd_ready
  );

endinterface

// File: rtl/fault_dncnt.sv
// Saturating down-counter with load and enable,
// shared by the delay and drive windows.
module fault_dncnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/jk_fault_driver.sv
// Drives one jk_ff cell's J/K pair for a timed
// window, with optional restore of its old value.
module jk_fault_driver
  import fault_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  jk_fault_driver_if.slave cmd,
  input  logic             abort,
  input  logic [WIDTH-1:0] q_obs,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             aborted
);

  localparam int IDX_W = idx_width(WIDTH);
  localparam logic [IDX_W:0] IDX_LIM =
    (IDX_W+1)'(WIDTH);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] dur_q, dur_d;
  logic             rflag_q, rflag_d;
  logic             orig_q, orig_d;
  logic             bad_q, bad_d;
  logic             ab_q, ab_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] j_q, j_d;
  logic [WIDTH-1:0] k_q, k_d;

  logic             cnt_load;
  logic             cnt_en;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;
  logic [CNT_W-1:0] dur_last;
  logic             idx_bad;
  logic [WIDTH-1:0] sel_in;
  logic [WIDTH-1:0] sel_q;

  fault_dncnt #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  assign idx_bad  = ({1'b0, cmd.cmd_idx} >= IDX_LIM);
  assign sel_in   = WIDTH'(1) << cmd.cmd_idx;
  assign sel_q    = WIDTH'(1) << idx_q;
  assign dur_last = (dur_q == '0) ? '0
                                  : dur_q - 1'b1;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    mode_d   = mode_q;
    dur_d    = dur_q;
    rflag_d  = rflag_q;
    orig_d   = orig_q;
    bad_d    = bad_q;
    ab_d     = ab_q;
    err_d    = 1'b0;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    cnt_val  = cmd.cmd_delay;
    j_d      = '0;
    k_d      = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd.cmd_valid) begin
          state_d  = ST_DELAY;
          idx_d    = cmd.cmd_idx;
          mode_d   = cmd.cmd_mode;
          dur_d    = cmd.cmd_dur;
          rflag_d  = cmd.cmd_restore;
          bad_d    = idx_bad;
          orig_d   = |(q_obs & sel_in);
          ab_d     = 1'b0;
          cnt_load = 1'b1;
        end
      end
      // DELAY spans D+1 cycles so the drive
      // window opens one edge after the count.
      ST_DELAY: begin
        if (abort) begin
          state_d = ST_DONE;
          ab_d    = 1'b1;
        end else if (bad_q) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else if (cnt_zero) begin
          state_d  = ST_ACTIVE;
          cnt_load = 1'b1;
          cnt_val  = dur_last;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (abort) begin
          state_d = ST_DONE;
          ab_d    = 1'b1;
        end else if (cnt_zero) begin
          state_d = rflag_q ? ST_RESTORE
                            : ST_DONE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_RESTORE: begin
        state_d = ST_DONE;
        if (abort) begin
          ab_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered against the next
    // state so J/K line up with the FSM.
    if (state_d == ST_ACTIVE) begin
      j_d = mode_q[1] ? sel_q : '0;
      k_d = mode_q[0] ? sel_q : '0;
    end else if (state_d == ST_RESTORE) begin
      j_d = orig_q ? sel_q : '0;
      k_d = orig_q ? '0 : sel_q;
    end
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      mode_q  <= MODE_HOLD;
      dur_q   <= '0;
      rflag_q <= 1'b0;
      orig_q  <= 1'b0;
      bad_q   <= 1'b0;
      ab_q    <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      j_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      dur_q   <= dur_d;
      rflag_q <= rflag_d;
      orig_q  <= orig_d;
      bad_q   <= bad_d;
      ab_q    <= ab_d;
      err_q   <= err_d;
      done_q  <= done_d;
      j_q     <= j_d;
      k_q     <= k_d;
    end
  end

  assign cmd.cmd_ready = (state_q == ST_IDLE);
  assign busy          = (state_q != ST_IDLE);
  assign j_out         = j_q;
  assign k_out         = k_q;
  assign done          = done_q;
  assign err           = err_q;
  assign aborted       = ab_q;

endmodule

// File: tb/tb_jk_fault_driver.sv
// Scoreboard bench for jk_fault_driver: random
// commands vs. a timeline model of each command.
module tb_jk_fault_driver;

  localparam int W  = 6;
  localparam int CW = 16;
  localparam int IW = 3;

  typedef struct {
    int         cyc;
    logic [W-1:0] j;
    logic [W-1:0] k;
    logic       dn;
    logic       er;
    logic       ab;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         abort;
  logic [W-1:0] q_obs;
  logic [W-1:0] j_out;
  logic [W-1:0] k_out;
  logic         busy, done, err, aborted;

  jk_fault_driver_if #(.WIDTH(W), .CNT_W(CW)) cif ();

  jk_fault_driver #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk     (clk),
    .rst     (rst),
    .cmd     (cif),
    .abort   (abort),
    .q_obs   (q_obs),
    .j_out   (j_out),
    .k_out   (k_out),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .aborted (aborted)
  );

  ev_t exq[$];
  int  total  = 0;
  int  bad    = 0;
  int  cyc    = 0;
  int  e0_m   = 0;
  int  done_m = -1;
  bit  chk_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_ev(input int c,
                         input logic [W-1:0] j,
                         input logic [W-1:0] k,
                         input logic dn,
                         input logic er,
                         input logic ab);
    ev_t t;
    t.cyc = c; t.j = j; t.k = k;
    t.dn = dn; t.er = er; t.ab = ab;
    exq.push_back(t);
  endtask

  // monitor: per-cycle invariants plus event matching
  always @(negedge clk) begin
    ev_t e;
    bit  exp_rdy;
    if (chk_on && !rst) begin
      exp_rdy = !(cyc >= e0_m && cyc <= done_m);
      total++;
      if (cif.cmd_ready !== exp_rdy) begin
        bad++;
        $display("FAIL ready cyc=%0d got=%b exp=%b",
                 cyc, cif.cmd_ready, exp_rdy);
      end
      total++;
      if (busy !== ~cif.cmd_ready) begin
        bad++;
        $display("FAIL busy cyc=%0d got=%b exp=%b",
                 cyc, busy, ~cif.cmd_ready);
      end
      total++;
      if (!$onehot0(j_out | k_out)) begin
        bad++;
        $display("FAIL onehot cyc=%0d j=%h k=%h",
                 cyc, j_out, k_out);
      end
      while (exq.size() > 0 && exq[0].cyc < cyc) begin
        total++;
        bad++;
        $display("FAIL missing cyc=%0d exp j=%h k=%h d=%b",
                 exq[0].cyc, exq[0].j, exq[0].k, exq[0].dn);
        void'(exq.pop_front());
      end
      if ((j_out | k_out) != '0 || done || err) begin
        total++;
        if (exq.size() == 0 || exq[0].cyc != cyc) begin
          bad++;
          $display("FAIL unexpected cyc=%0d j=%h k=%h d=%b e=%b",
                   cyc, j_out, k_out, done, err);
        end else begin
          e = exq.pop_front();
          if (j_out !== e.j || k_out !== e.k ||
              done !== e.dn || err !== e.er ||
              (e.dn && aborted !== e.ab) ||
              (!e.dn && aborted !== 1'b0)) begin
            bad++;
            $display("FAIL event cyc=%0d got j=%h k=%h d=%b e=%b a=%b exp j=%h k=%h d=%b e=%b a=%b",
                     cyc, j_out, k_out, done, err, aborted,
                     e.j, e.k, e.dn, e.er, e.ab);
          end
        end
      end
    end
  end

  task automatic issue(input int idx,
                       input logic [1:0] mode,
                       input int d,
                       input int dur,
                       input bit rs,
                       input logic [W-1:0] q,
                       input int ab_k,
                       input bit hold,
                       input bit chained);
    int e0, n, dn, fd, ca, t, c;
    bit badi, ab;
    logic [W-1:0] bm;
    @(negedge clk);
    cif.cmd_valid   = 1'b1;
    cif.cmd_idx     = IW'(idx);
    cif.cmd_mode    = mode;
    cif.cmd_delay   = CW'(d);
    cif.cmd_dur     = CW'(dur);
    cif.cmd_restore = rs;
    q_obs           = q;
    t = 0;
    while (cif.cmd_ready !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) begin
      total++;
      bad++;
      $display("FAIL accept_timeout cyc=%0d", cyc);
      cif.cmd_valid = 1'b0;
      return;
    end
    e0 = cyc + 1;
    total++;
    if (chained ? (e0 != done_m + 2) : (e0 < done_m + 2)) begin
      bad++;
      $display("FAIL accept_time got=%0d prev_done=%0d",
               e0, done_m);
    end
    badi = (idx >= W);
    n    = (dur == 0) ? 1 : dur;
    bm   = '0;
    if (!badi) bm[idx] = 1'b1;
    dn = badi ? e0 + 1 : e0 + d + n + 1 + (rs ? 1 : 0);
    ca = (ab_k >= 0) ? e0 + ab_k : -1;
    ab = (ab_k >= 0) && (ca < dn);
    fd = ab ? ca + 1 : dn;
    if (!badi) begin
      if (mode != 2'b00) begin
        for (int i = 1; i <= n; i++) begin
          c = e0 + d + i;
          if (!ab || c <= ca)
            push_ev(c, mode[1] ? bm : '0,
                    mode[0] ? bm : '0, 0, 0, 0);
        end
      end
      if (rs) begin
        c = e0 + d + n + 1;
        if (!ab || c <= ca)
          push_ev(c, q[idx] ? bm : '0,
                  q[idx] ? '0 : bm, 0, 0, 0);
      end
    end
    push_ev(fd, '0, '0, 1'b1, badi && !ab, ab);
    e0_m   = e0;
    done_m = fd;
    @(negedge clk);
    if (!hold) cif.cmd_valid = 1'b0;
    if (ab_k >= 0) begin
      while (cyc < ca) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end
  endtask

  task automatic drain();
    int t = 0;
    while (cyc <= done_m + 1 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    total++;
    if (exq.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d", exq.size());
    end
  endtask

  initial begin
    int idx, d, dur, abk;
    logic [1:0] mode;
    bit rs;
    cif.cmd_valid   = 1'b0;
    cif.cmd_idx     = '0;
    cif.cmd_mode    = 2'b00;
    cif.cmd_delay   = '0;
    cif.cmd_dur     = '0;
    cif.cmd_restore = 1'b0;
    abort = 1'b0;
    q_obs = '0;

    repeat (2) @(negedge clk);
    total++;
    if (j_out !== '0 || k_out !== '0 || done !== 1'b0 ||
        err !== 1'b0 || aborted !== 1'b0 ||
        cif.cmd_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_state j=%h k=%h d=%b e=%b a=%b r=%b b=%b",
               j_out, k_out, done, err, aborted,
               cif.cmd_ready, busy);
    end
    rst = 1'b0;
    chk_on = 1'b1;

    issue(3, 2'b10, 0, 2, 0, 6'h00, -1, 0, 0);
    issue(0, 2'b11, 4, 3, 1, 6'h3e, -1, 0, 0);
    issue(5, 2'b01, 0, 10, 0, 6'h21, 4, 0, 0);
    issue(1, 2'b10, 1, 2, 0, 6'h00, -1, 1, 0);
    issue(2, 2'b01, 0, 1, 1, 6'h04, -1, 0, 1);
    issue(7, 2'b10, 0, 2, 0, 6'h00, -1, 0, 0);
    issue(6, 2'b11, 1, 1, 1, 6'h3f, -1, 0, 0);
    issue(4, 2'b11, 2, 0, 0, 6'h00, -1, 0, 0);
    issue(2, 2'b00, 1, 2, 1, 6'h04, -1, 0, 0);
    drain();

    for (int r = 0; r < 40; r++) begin
      idx  = $urandom_range(0, 7);
      mode = 2'($urandom_range(0, 3));
      d    = $urandom_range(0, 5);
      dur  = $urandom_range(0, 4);
      rs   = 1'($urandom_range(0, 1));
      abk  = ($urandom_range(0, 3) == 0) ?
             $urandom_range(0, d + dur + 3) : -1;
      issue(idx, mode, d, dur, rs, W'($urandom),
            abk, 0, 0);
    end
    drain();

    issue(2, 2'b10, 0, 20, 0, 6'h00, -1, 0, 0);
    repeat (3) @(negedge clk);
    total++;
    if (j_out !== 6'h04) begin
      bad++;
      $display("FAIL pre_reset_drive got=%h exp=%h",
               j_out, 6'h04);
    end
    #2;
    chk_on = 1'b0;
    rst = 1'b1;
    #1;
    total++;
    if (j_out !== '0 || k_out !== '0) begin
      bad++;
      $display("FAIL async_reset j=%h k=%h exp 0",
               j_out, k_out);
    end
    exq.delete();
    e0_m = 0;
    done_m = -1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (cif.cmd_ready !== 1'b1 || busy !== 1'b0 ||
        done !== 1'b0) begin
      bad++;
      $display("FAIL post_reset r=%b b=%b d=%b exp 1/0/0",
               cif.cmd_ready, busy, done);
    end
    chk_on = 1'b1;
    issue(0, 2'b11, 0, 1, 1, 6'h01, -1, 0, 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
